sentinel_seq_lock: RTL and testbench
====================================

# sentinel_seq_lock

Parametrised multi-byte successor to the single-byte Sentinel gate. A configurable key sequence must be presented byte-by-byte on a strobed 8-bit port. The block counts failed sequences and enters a timed lockout after a set number of failures. It drives the same 7-segment and status-array conventions (common anode, active-LOW segments; status glow), and sits between the DIP/keypad front end and the top-level pads.

## Interface
Parameters:
- KEY_LEN, 4: key length in bytes, 1..16
- KEY, 32'h0FC3_5AB6: packed key, width 8*KEY_LEN; byte 0 (KEY[7:0]) is entered first
- MAX_FAILS, 3: failed sequences before lockout, 1..15
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles, ≥1
- ENTRY_TIMEOUT, 255: idle cycles allowed between strobes mid-entry, ≥1

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ena  in  1  power-state enable; low freezes all state and blanks outputs
- key_in  in  8  key byte, sampled only when key_stb=1
- key_stb  in  1  single-cycle byte strobe
- relock  in  1  level; returns UNLOCKED to IDLE
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, active LOW
- status_out  out  8  status array
- unlocked  out  1  high in UNLOCKED
- lockout  out  1  high in LOCKOUT

## Operation
- State machine states:
  - IDLE: locked, index 0
  - ENTRY: index > 0
  - UNLOCKED
  - LOCKOUT
- Registers:
  - state
  - idx: clog2(KEY_LEN+1) bits
  - mismatch flag
  - fail_cnt: 4 bits
  - lock_tmr: clog2(LOCKOUT_CYCLES) bits, min 1
  - ent_tmr: clog2(ENTRY_TIMEOUT) bits, min 1
- Accepted strobe = key_stb & ena, in IDLE or ENTRY only. Strobes are ignored in UNLOCKED and LOCKOUT.
- Per accepted strobe:
  - Compare key_in with KEY byte[idx].
  - mismatch |= (key_in != byte).
  - idx++.
  - ent_tmr cleared.
- A mismatch never aborts early. All KEY_LEN bytes are always consumed, so no timing leak.
- On the KEY_LEN-th accepted strobe, the result uses the current byte's compare as well:
  - All match: go to UNLOCKED; fail_cnt=0.
  - Otherwise, fail_cnt+1:
    - If the new value equals MAX_FAILS: go to LOCKOUT; lock_tmr=LOCKOUT_CYCLES-1.
    - Else: go to IDLE.
  - In both cases idx=0 and mismatch=0.
- KEY_LEN=1: IDLE resolves directly on the strobe; ENTRY is never entered.
- ENTRY timeout:
  - ent_tmr increments each enabled cycle without a strobe.
  - When it reaches ENTRY_TIMEOUT-1 with no strobe: go to IDLE, idx=0, mismatch=0.
  - fail_cnt is unchanged (abandoned entry is not a failure).
  - A strobe in that same cycle wins.
- LOCKOUT: lock_tmr decrements each enabled cycle. At 0, next state is IDLE and fail_cnt=0.
- UNLOCKED: relock=1 moves to IDLE. A simultaneous key_stb is dropped (relock wins).
- ena=0: no state, counter or timer changes; strobes lost.
- Output decode (combinational from registered state and ena):
  - ena=0: seg_out=0xFF, status_out=0x00, unlocked=0, lockout=0.
  - IDLE: seg_out=0xC7 ('L').
  - ENTRY: seg_out=0x47 ('L' + dp).
  - UNLOCKED: seg_out=0xC1 ('U').
  - LOCKOUT: seg_out=0x86 ('E').
  - status_out=0xFF in UNLOCKED; else {lockout, 3'b000, fail_cnt}.
- Reset values:
  - Registers: state=IDLE, idx=0, mismatch=0, fail_cnt=0, timers=0.
  - Outputs with ena=1: seg_out=0xC7, status_out=0x00, unlocked=0, lockout=0.
- Reset mid-operation: immediate return to reset values from any state, including LOCKOUT (lockout cleared).

## Timing
- Final strobe sampled at edge T: unlocked or lockout is high after edge T (the following cycle). Latency is 1 cycle.
- LOCKOUT lasts exactly LOCKOUT_CYCLES enabled cycles, then IDLE.
- ENTRY without strobes lasts exactly ENTRY_TIMEOUT enabled cycles, then IDLE.
- Back-to-back strobes on consecutive cycles are legal. No throughput limit.
- Cycles with ena low extend all durations 1:1.
- Outputs are glitch-free relative to clk; no clock gating.

## Test plan
- Defaults: strobe B6,5A,C3,0F on consecutive cycles -> seg_out 0x47 after first byte; 0xC1, status_out 0xFF, unlocked=1 one cycle after 4th; relock=1 -> 0xC7 next cycle.
- Wrong 2nd byte (B6,00,C3,0F) -> no early abort; 0xC7 after 4th byte, status_out 0x01. Repeat twice more -> status_out 0x83, seg 0x86, lockout=1 for exactly 1000 cycles. Strobes during LOCKOUT are ignored. Then 0xC7, status_out 0x00.
- Strobe B6 then 255 idle cycles -> IDLE (0xC7), fail_cnt unchanged. Strobe on cycle 255 -> accepted, stays in ENTRY.
- Unlock, then relock=1 and key_stb=1 with B6 in same cycle -> IDLE with idx=0 (next seg 0xC7, not 0x47).
- rst_n low mid-entry and mid-LOCKOUT -> asynchronous return to 0xC7/0x00. Full correct key then unlocks.
- ena=0 for 50 cycles during LOCKOUT with strobes applied -> outputs 0xFF/0x00, timer frozen. Lockout ends 50 cycles late. KEY_LEN=1, KEY=8'hB6: single B6 strobe unlocks.

Source files
------------

// File: rtl/sentinel_seq_lock.sv
// sentinel_seq_lock: multi-byte key sequence gate with failure counting and
// timed lockout. Drives a common-anode 7-segment digit (active-LOW segments)
// and an 8-bit status array.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | locked, waiting for the first key byte (idx = 0)
// ENTRY    | sequence in progress (idx > 0), entry timer running
// UNLOCKED | full key matched; held until relock
// LOCKOUT  | MAX_FAILS bad sequences; lock timer counting down to IDLE
module sentinel_seq_lock #(
    parameter int unsigned          KEY_LEN        = 4,
    parameter logic [8*KEY_LEN-1:0] KEY            = 32'h0FC3_5AB6,
    parameter int unsigned          MAX_FAILS      = 3,
    parameter int unsigned          LOCKOUT_CYCLES = 1000,
    parameter int unsigned          ENTRY_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] key_in,
    input  logic       key_stb,
    input  logic       relock,
    output logic [7:0] seg_out,
    output logic [7:0] status_out,
    output logic       unlocked,
    output logic       lockout
);

    localparam int unsigned IDX_W = $clog2(KEY_LEN + 1);
    localparam int unsigned LT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int unsigned ET_W  = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_LEN - 1);
    localparam logic [LT_W-1:0]  LT_LOAD  = LT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [ET_W-1:0]  ET_LAST  = ET_W'(ENTRY_TIMEOUT - 1);
    localparam logic [3:0]       FAIL_MAX = 4'(MAX_FAILS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mis_q, mis_d;
    logic [3:0]       fail_q, fail_d;
    logic [LT_W-1:0]  lt_q, lt_d;
    logic [ET_W-1:0]  et_q, et_d;

    logic [7:0]       key_byte;
    logic             byte_miss;

    // Select the expected key byte for the current index.
    always_comb begin
        key_byte = 8'h00;
        for (int i = 0; i < int'(KEY_LEN); i++) begin
            if (idx_q == IDX_W'(i)) begin
                key_byte = KEY[i*8 +: 8];
            end
        end
        byte_miss = (key_in != key_byte);
    end

    // State and counter registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            fail_q  <= 4'd0;
            lt_q    <= '0;
            et_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            fail_q  <= fail_d;
            lt_q    <= lt_d;
            et_q    <= et_d;
        end
    end

    // Next-state logic. A mismatch only sets a sticky flag so every sequence
    // consumes all KEY_LEN bytes regardless of where it went wrong.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        fail_d  = fail_q;
        lt_d    = lt_q;
        et_d    = et_q;
        if (ena) begin
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (key_stb) begin
                        et_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            mis_d = 1'b0;
                            if (!(mis_q || byte_miss)) begin
                                state_d = ST_UNLOCKED;
                                fail_d  = 4'd0;
                            end else if (fail_q + 4'd1 == FAIL_MAX) begin
                                state_d = ST_LOCKOUT;
                                fail_d  = fail_q + 4'd1;
                                lt_d    = LT_LOAD;
                            end else begin
                                state_d = ST_IDLE;
                                fail_d  = fail_q + 4'd1;
                            end
                        end else begin
                            state_d = ST_ENTRY;
                            idx_d   = idx_q + IDX_W'(1);
                            mis_d   = mis_q | byte_miss;
                        end
                    end else if (state_q == ST_ENTRY) begin
                        // Abandoned entry returns to IDLE without counting a failure.
                        if (et_q == ET_LAST) begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                            mis_d   = 1'b0;
                            et_d    = '0;
                        end else begin
                            et_d = et_q + ET_W'(1);
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (relock) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (lt_q == '0) begin
                        state_d = ST_IDLE;
                        fail_d  = 4'd0;
                    end else begin
                        lt_d = lt_q - LT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from registered state; blanked while ena is low.
    always_comb begin
        seg_out    = 8'hFF;
        status_out = 8'h00;
        unlocked   = 1'b0;
        lockout    = 1'b0;
        if (ena) begin
            case (state_q)
                ST_IDLE:     seg_out = 8'hC7;
                ST_ENTRY:    seg_out = 8'h47;
                ST_UNLOCKED: begin
                    seg_out  = 8'hC1;
                    unlocked = 1'b1;
                end
                ST_LOCKOUT:  begin
                    seg_out = 8'h86;
                    lockout = 1'b1;
                end
                default:     seg_out = 8'hFF;
            endcase
            status_out = (state_q == ST_UNLOCKED) ? 8'hFF
                                                  : {(state_q == ST_LOCKOUT), 3'b000, fail_q};
        end
    end

endmodule

// File: tb/tb_sentinel_seq_lock.sv
// Directed testbench for sentinel_seq_lock: default 4-byte key instance plus
// a single-byte key instance.
module tb_sentinel_seq_lock;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] key_in;
    logic       key_stb;
    logic       relock;
    logic [7:0] seg_out;
    logic [7:0] status_out;
    logic       unlocked;
    logic       lockout;

    logic [7:0] key_in2;
    logic       key_stb2;
    logic       relock2;
    logic [7:0] seg_out2;
    logic [7:0] status_out2;
    logic       unlocked2;
    logic       lockout2;

    int n_tests = 0;
    int n_fail  = 0;

    sentinel_seq_lock dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .key_in     (key_in),
        .key_stb    (key_stb),
        .relock     (relock),
        .seg_out    (seg_out),
        .status_out (status_out),
        .unlocked   (unlocked),
        .lockout    (lockout)
    );

    sentinel_seq_lock #(
        .KEY_LEN (1),
        .KEY     (8'hB6)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .key_in     (key_in2),
        .key_stb    (key_stb2),
        .relock     (relock2),
        .seg_out    (seg_out2),
        .status_out (status_out2),
        .unlocked   (unlocked2),
        .lockout    (lockout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stb(input logic [7:0] b);
        key_in  = b;
        key_stb = 1'b1;
        tick(1);
        key_stb = 1'b0;
        key_in  = 8'h00;
    endtask

    task automatic seq4(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        stb(b0);
        stb(b1);
        stb(b2);
        stb(b3);
    endtask

    task automatic do_relock();
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        ena      = 1'b1;
        key_in   = 8'h00;
        key_stb  = 1'b0;
        relock   = 1'b0;
        key_in2  = 8'h00;
        key_stb2 = 1'b0;
        relock2  = 1'b0;
        #3;
        check("rst_seg",      seg_out, 8'hC7);
        check("rst_status",   status_out, 8'h00);
        check("rst_unlocked", 8'(unlocked), 8'h00);
        check("rst_lockout",  8'(lockout), 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // single-byte key instance
        key_in2 = 8'h00; key_stb2 = 1'b1; tick(1); key_stb2 = 1'b0;
        check("k1_wrong_seg",    seg_out2, 8'hC7);
        check("k1_wrong_status", status_out2, 8'h01);
        key_in2 = 8'hB6; key_stb2 = 1'b1; tick(1); key_stb2 = 1'b0;
        check("k1_unlock_seg",   seg_out2, 8'hC1);
        check("k1_unlock_flag",  8'(unlocked2), 8'h01);

        // correct key
        stb(8'hB6);
        check("ok_first_seg", seg_out, 8'h47);
        stb(8'h5A);
        stb(8'hC3);
        check("ok_third_seg", seg_out, 8'h47);
        stb(8'h0F);
        check("ok_seg",      seg_out, 8'hC1);
        check("ok_status",   status_out, 8'hFF);
        check("ok_unlocked", 8'(unlocked), 8'h01);
        tick(3);
        check("ok_hold_seg", seg_out, 8'hC1);
        do_relock();
        check("relock_seg",  seg_out, 8'hC7);
        check("relock_unl",  8'(unlocked), 8'h00);

        // wrong second byte: no early abort
        stb(8'hB6);
        stb(8'h00);
        check("bad_noabort_seg", seg_out, 8'h47);
        stb(8'hC3);
        stb(8'h0F);
        check("bad1_seg",    seg_out, 8'hC7);
        check("bad1_status", status_out, 8'h01);

        // entry timeout keeps fail count
        stb(8'hB6);
        tick(254);
        check("to_last_seg", seg_out, 8'h47);
        tick(1);
        check("to_idle_seg",    seg_out, 8'hC7);
        check("to_idle_status", status_out, 8'h01);

        // strobe in the final timeout cycle is accepted
        stb(8'hB6);
        tick(254);
        stb(8'h5A);
        check("to_edge_seg", seg_out, 8'h47);
        stb(8'hC3);
        stb(8'h0F);
        check("to_edge_unl",    8'(unlocked), 8'h01);
        do_relock();
        check("to_edge_status", status_out, 8'h00);

        // three failures -> lockout of exactly 1000 cycles, strobes ignored
        seq4(8'hB6, 8'h00, 8'hC3, 8'h0F);
        seq4(8'hB6, 8'h00, 8'hC3, 8'h0F);
        check("bad2_status", status_out, 8'h02);
        seq4(8'hB6, 8'h00, 8'hC3, 8'h0F);
        check("lock_status", status_out, 8'h83);
        check("lock_seg",    seg_out, 8'h86);
        check("lock_flag",   8'(lockout), 8'h01);
        bad = 0;
        for (int i = 1; i < 1000; i++) begin
            key_stb = (i >= 100 && i < 104);
            case (i)
                100: key_in = 8'hB6;
                101: key_in = 8'h5A;
                102: key_in = 8'hC3;
                103: key_in = 8'h0F;
                default: key_in = 8'h00;
            endcase
            tick(1);
            if (lockout !== 1'b1) bad++;
        end
        key_stb = 1'b0;
        check("lock_held_cycles", 8'(bad), 8'h00);
        check("lock_last_flag", 8'(lockout), 8'h01);
        tick(1);
        check("lock_end_flag",   8'(lockout), 8'h00);
        check("lock_end_seg",    seg_out, 8'hC7);
        check("lock_end_status", status_out, 8'h00);

        // relock and strobe together: relock wins, strobe dropped
        seq4(8'hB6, 8'h5A, 8'hC3, 8'h0F);
        check("rs_unl", 8'(unlocked), 8'h01);
        relock  = 1'b1;
        key_in  = 8'hB6;
        key_stb = 1'b1;
        tick(1);
        relock  = 1'b0;
        key_stb = 1'b0;
        check("rs_seg", seg_out, 8'hC7);
        seq4(8'hB6, 8'h5A, 8'hC3, 8'h0F);
        check("rs_reunl", 8'(unlocked), 8'h01);
        do_relock();

        // asynchronous reset mid-entry
        stb(8'hB6);
        stb(8'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("arst_entry_seg",    seg_out, 8'hC7);
        check("arst_entry_status", status_out, 8'h00);
        tick(1);
        rst_n = 1'b1;
        seq4(8'hB6, 8'h5A, 8'hC3, 8'h0F);
        check("arst_entry_unl", 8'(unlocked), 8'h01);
        do_relock();

        // asynchronous reset mid-lockout
        repeat (3) seq4(8'h11, 8'h22, 8'h33, 8'h44);
        check("arst_lock_pre", 8'(lockout), 8'h01);
        tick(10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_lock_flag",   8'(lockout), 8'h00);
        check("arst_lock_seg",    seg_out, 8'hC7);
        check("arst_lock_status", status_out, 8'h00);
        tick(1);
        rst_n = 1'b1;
        seq4(8'hB6, 8'h5A, 8'hC3, 8'h0F);
        check("arst_lock_unl", 8'(unlocked), 8'h01);
        do_relock();

        // ena low for 50 cycles during lockout stretches it by 50
        repeat (3) seq4(8'hB6, 8'h5A, 8'hC3, 8'h00);
        check("ena_lock_seg", seg_out, 8'h86);
        tick(99);
        ena     = 1'b0;
        key_in  = 8'hB6;
        key_stb = 1'b1;
        #1;
        check("ena_off_seg",    seg_out, 8'hFF);
        check("ena_off_status", status_out, 8'h00);
        check("ena_off_lock",   8'(lockout), 8'h00);
        tick(50);
        check("ena_off_unl", 8'(unlocked), 8'h00);
        key_stb = 1'b0;
        key_in  = 8'h00;
        ena     = 1'b1;
        #1;
        check("ena_back_status", status_out, 8'h83);
        tick(900);
        check("ena_lock_late", 8'(lockout), 8'h01);
        tick(1);
        check("ena_lock_end",     8'(lockout), 8'h00);
        check("ena_lock_end_seg", seg_out, 8'hC7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
